dm_s2mm_cmd_responder: RTL and testbench

Responder side of the DataMover S2MM command/status interface. It accepts 72-bit commands, moves BTT bytes from an AXI-Stream slave onto a simple memory write port, then returns an 8-bit status carrying the command tag. It is used as a simulation and bring-up stand-in for the DataMover and sits directly behind the command-issuing controller.

---
 rtl/dm_resp_pkg.sv | 39 +++
 rtl/dm_s2mm_cmd_responder.sv | 158 +++++++++++++++
 tb/tb_dm_s2mm_cmd_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_resp_pkg.sv
// Shared types and field positions for the S2MM command responder:
// FSM states, command/status bit layout and the decoded command struct.
package dm_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DATA,
        ST_DRAIN,
        ST_STS
    } state_e;

    localparam int TAG_MSB   = 67;
    localparam int TAG_LSB   = 64;
    localparam int SADDR_MSB = 63;
    localparam int SADDR_LSB = 32;
    localparam int BTT_MSB   = 22;
    localparam int BTT_LSB   = 0;

    localparam int OKAY_BIT   = 7;
    localparam int SLVERR_BIT = 6;
    localparam int DECERR_BIT = 5;
    localparam int INTERR_BIT = 4;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] saddr;
        logic [22:0] btt;
    } cmd_t;

    // One-hot status byte with only the given result bit set.
    function automatic logic [7:0] sts_bit(input int b);
        logic [7:0] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dm_s2mm_cmd_responder.sv
// DataMover S2MM command/status responder: takes one command, writes BTT bytes
// from the stream to memory, returns a tagged status. Optional DM_RESP_TLAST_CHECK_EN.
module dm_s2mm_cmd_responder
    import dm_resp_pkg::*;
#(
    parameter int          DATA_BYTES = 8,
    parameter logic [32:0] MEM_BYTES  = 33'h0_1000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [71:0]             s_cmd_tdata,
    input  logic                    s_cmd_tvalid,
    output logic                    s_cmd_tready,
    output logic [7:0]              m_sts_tdata,
    output logic                    m_sts_tkeep,
    output logic                    m_sts_tlast,
    output logic                    m_sts_tvalid,
    input  logic                    m_sts_tready,
    input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [31:0]             mem_addr,
    output logic [8*DATA_BYTES-1:0] mem_wdata,
    output logic                    mem_we,
    input  logic                    mem_ready,
    output logic                    busy
);

    localparam int          OFS  = $clog2(DATA_BYTES);
    localparam logic [31:0] STEP = 32'(DATA_BYTES);

    state_e      r_state;
    state_e      w_next;
    cmd_t        r_cmd;
    cmd_t        w_cmd;
    logic [31:0] r_addr;
    logic [22:0] r_beats;
    logic [7:0]  r_sts;
    logic        r_tl_err;

    logic [7:0]  w_sts;
    logic [32:0] w_end;
    logic        w_oob;
    logic        w_bad_cmd;
    logic        w_last;
    logic        w_xfer;
    logic        w_tl_bad;
    logic        w_done_err;
    logic        w_unused;

    assign w_cmd = '{tag:   s_cmd_tdata[TAG_MSB:TAG_LSB],
                     saddr: s_cmd_tdata[SADDR_MSB:SADDR_LSB],
                     btt:   s_cmd_tdata[BTT_MSB:BTT_LSB]};

    // 33-bit end address so a transfer wrapping past 4 GiB is out of range too.
    assign w_end     = {1'b0, r_cmd.saddr} + {10'b0, r_cmd.btt};
    assign w_oob     = w_end > MEM_BYTES;
    assign w_bad_cmd = (r_cmd.btt == '0) || (r_cmd.btt[OFS-1:0] != '0) ||
                       (r_cmd.saddr[OFS-1:0] != '0);
    assign w_last    = (r_beats == 23'd1);
    assign w_xfer    = ((r_state == ST_DATA) && s_axis_tvalid && mem_ready) ||
                       ((r_state == ST_DRAIN) && s_axis_tvalid);

`ifdef DM_RESP_TLAST_CHECK_EN
    assign w_tl_bad = w_xfer && (s_axis_tlast != w_last);
`else
    assign w_tl_bad = 1'b0;
`endif
    assign w_done_err = r_tl_err || w_tl_bad;
    assign w_unused   = ^{s_cmd_tdata[71:68], s_cmd_tdata[31:23], s_axis_tlast};

    always_comb begin
        w_next        = r_state;
        w_sts         = r_sts;
        s_cmd_tready  = 1'b0;
        m_sts_tvalid  = 1'b0;
        s_axis_tready = 1'b0;
        mem_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                s_cmd_tready = !reset;
                if (s_cmd_tvalid) begin
                    w_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_bad_cmd) begin
                    w_next = ST_STS;
                    w_sts  = sts_bit(INTERR_BIT);
                end else if (w_oob) begin
                    w_next = ST_DRAIN;
                end else begin
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                s_axis_tready = mem_ready;
                mem_we        = s_axis_tvalid && mem_ready;
                if (w_xfer && w_last) begin
                    w_next = ST_STS;
                    w_sts  = w_done_err ? sts_bit(INTERR_BIT) : sts_bit(OKAY_BIT);
                end
            end
            ST_DRAIN: begin
                s_axis_tready = 1'b1;
                if (w_xfer && w_last) begin
                    w_next = ST_STS;
                    w_sts  = w_done_err ? sts_bit(INTERR_BIT) : sts_bit(DECERR_BIT);
                end
            end
            ST_STS: begin
                m_sts_tvalid = 1'b1;
                if (m_sts_tready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cmd    <= '0;
            r_addr   <= '0;
            r_beats  <= '0;
            r_sts    <= '0;
            r_tl_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sts   <= w_sts;
            if ((r_state == ST_IDLE) && s_cmd_tvalid) begin
                r_cmd    <= w_cmd;
                r_addr   <= w_cmd.saddr;
                r_tl_err <= 1'b0;
            end
            if (r_state == ST_CHECK) begin
                r_beats <= r_cmd.btt >> OFS;
            end
            if (w_xfer) begin
                r_addr  <= r_addr + STEP;
                r_beats <= r_beats - 23'd1;
                if (w_tl_bad) begin
                    r_tl_err <= 1'b1;
                end
            end
        end
    end

    assign m_sts_tdata = r_sts | {4'h0, r_cmd.tag};
    assign m_sts_tkeep = 1'b1;
    assign m_sts_tlast = 1'b1;
    assign mem_addr    = r_addr;
    assign mem_wdata   = s_axis_tdata;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dm_s2mm_cmd_responder.sv
// Directed plus randomized bench for dm_s2mm_cmd_responder (DATA_BYTES=8,
// MEM_BYTES=2**28); expected status and writes come from a command-level model.
module tb_dm_s2mm_cmd_responder;

    localparam int DB = 8;
    localparam int W  = 8 * DB;
`ifdef DM_RESP_TLAST_CHECK_EN
    localparam bit TL_CHK = 1'b1;
`else
    localparam bit TL_CHK = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [71:0]  s_cmd_tdata;
    logic         s_cmd_tvalid;
    logic         s_cmd_tready;
    logic [7:0]   m_sts_tdata;
    logic         m_sts_tkeep;
    logic         m_sts_tlast;
    logic         m_sts_tvalid;
    logic         m_sts_tready;
    logic [W-1:0] s_axis_tdata;
    logic         s_axis_tlast;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [31:0]  mem_addr;
    logic [W-1:0] mem_wdata;
    logic         mem_we;
    logic         mem_ready;
    logic         busy;

    dm_s2mm_cmd_responder #(
        .DATA_BYTES(DB),
        .MEM_BYTES (33'h0_1000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_cmd_tdata  (s_cmd_tdata),
        .s_cmd_tvalid (s_cmd_tvalid),
        .s_cmd_tready (s_cmd_tready),
        .m_sts_tdata  (m_sts_tdata),
        .m_sts_tkeep  (m_sts_tkeep),
        .m_sts_tlast  (m_sts_tlast),
        .m_sts_tvalid (m_sts_tvalid),
        .m_sts_tready (m_sts_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_ready    (mem_ready),
        .busy         (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // scoreboard: {addr, data} of every memory write
    logic [95:0] exp_q[$];
    logic [95:0] act_q[$];

    always @(posedge clk) begin
        if (!reset && mem_we && mem_ready) act_q.push_back({mem_addr, mem_wdata});
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Command-level reference: status byte from the command fields and stream behaviour.
    function automatic logic [7:0] model_sts(input logic [3:0] tag, input logic [31:0] saddr,
                                             input logic [22:0] btt, input bit tl_bad);
        logic [63:0] end_a;
        end_a = {32'b0, saddr} + {41'b0, btt};
        if (btt == 0 || btt % 8 != 0 || saddr % 8 != 0) return {4'b0001, tag};
        if (tl_bad && TL_CHK) return {4'b0001, tag};
        if (end_a > 64'h1000_0000) return {4'b0010, tag};
        return {4'b1000, tag};
    endfunction

    task automatic compare_writes();
        chk("write_count", 96'(act_q.size()), 96'(exp_q.size()));
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            chk("write_addr_data", act_q.pop_front(), exp_q.pop_front());
        end
        act_q.delete();
        exp_q.delete();
    endtask

    // driver: one command, its stream, its status; mode 1 = gapped stream + mem stalls
    task automatic run_cmd(input logic [3:0] tag, input logic [31:0] saddr, input logic [22:0] btt,
                           input int mode, input int bad_beat, input int abort_after);
        int          beats;
        int          cyc;
        int          idx;
        int          hold;
        bit          interr;
        bit          oob;
        bit          tl_bad;
        logic [7:0]  exp_sts;
        interr  = (btt == 0 || btt % 8 != 0 || saddr % 8 != 0);
        beats   = interr ? 0 : int'(btt / 8);
        oob     = ({32'b0, saddr} + {41'b0, btt}) > 64'h1000_0000;
        tl_bad  = (bad_beat >= 0) && (bad_beat != beats - 1);
        exp_sts = model_sts(tag, saddr, btt, tl_bad);
        act_q.delete();
        exp_q.delete();

        @(negedge clk);
        s_cmd_tdata  = {4'($urandom), tag, saddr, 8'($urandom), 1'($urandom), btt};
        s_cmd_tvalid = 1'b1;
        cyc = 0;
        #1;
        while (!s_cmd_tready && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("cmd_ready", 96'(s_cmd_tready), 96'(1));
        @(negedge clk);
        s_cmd_tvalid  = 1'b0;
        mem_ready     = 1'b1;
        s_axis_tvalid = 1'b0;
        #1;
        chk("check_state_readies", {93'b0, s_cmd_tready, s_axis_tready, busy}, 96'b001);

        idx = 0;
        cyc = 0;
        while (idx < beats && cyc < beats * 10 + 50) begin
            @(negedge clk);
            cyc++;
            if (abort_after > 0 && idx == abort_after) break;
            if (!s_axis_tvalid && (mode == 0 || $urandom_range(0, 1) == 1)) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = {$urandom, $urandom};
                s_axis_tlast  = (bad_beat >= 0) ? (idx == bad_beat) : (idx == beats - 1);
            end
            mem_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (s_axis_tvalid && s_axis_tready) begin
                if (!oob) exp_q.push_back({saddr + 32'(idx * 8), s_axis_tdata});
                idx++;
                @(posedge clk);
                #1;
                s_axis_tvalid = 1'b0;
            end
        end

        if (abort_after > 0) begin
            chk("abort_beats", 96'(idx), 96'(abort_after));
            reset = 1'b1;
            @(posedge clk);
            #1;
            chk("abort_reset_outputs",
                {91'b0, s_cmd_tready, m_sts_tvalid, s_axis_tready, mem_we, busy}, 96'b0);
            @(negedge clk);
            reset = 1'b0;
            #1;
            chk("abort_idle", {94'b0, s_cmd_tready, m_sts_tvalid}, 96'b10);
            compare_writes();
            return;
        end
        chk("beats_consumed", 96'(idx), 96'(beats));

        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {$urandom, $urandom};
        mem_ready     = 1'b1;
        @(negedge clk);
        #1;
        cyc = 0;
        while (!m_sts_tvalid && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("sts_valid", 96'(m_sts_tvalid), 96'(1));
        chk("no_stream_in_sts", {95'b0, s_axis_tready}, 96'b0);
        s_axis_tvalid = 1'b0;
        hold = $urandom_range(0, 3);
        for (int k = 0; k < hold; k++) begin
            chk("sts_hold", {87'b0, m_sts_tvalid, m_sts_tdata}, {87'b0, 1'b1, exp_sts});
            @(negedge clk);
            #1;
        end
        chk("sts_data", {88'b0, m_sts_tdata}, {88'b0, exp_sts});
        chk("sts_keep_last", {94'b0, m_sts_tkeep, m_sts_tlast}, 96'b11);
        m_sts_tready = 1'b1;
        #1;
        chk("cmd_blocked_in_sts", {95'b0, s_cmd_tready}, 96'b0);
        @(posedge clk);
        #1;
        m_sts_tready = 1'b0;
        chk("sts_dropped", {95'b0, m_sts_tvalid}, 96'b0);
        chk("idle_after_sts", {94'b0, busy, s_cmd_tready}, 96'b01);
        compare_writes();
    endtask

    logic [31:0] r_sa;
    logic [22:0] r_bt;

    initial begin
        reset         = 1'b1;
        s_cmd_tdata   = '0;
        s_cmd_tvalid  = 1'b0;
        m_sts_tready  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        mem_ready     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {91'b0, s_cmd_tready, m_sts_tvalid, s_axis_tready, mem_we, busy}, 96'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle_ready", {94'b0, s_cmd_tready, busy}, 96'b10);

        run_cmd(4'hA, 32'h0000_0000, 23'h1000, 0, -1, 0);    // full rate, OKAY
        run_cmd(4'hA, 32'h0000_2000, 23'h1000, 1, -1, 0);    // stalls and gaps
        run_cmd(4'h3, 32'h0000_0000, 23'h0000, 0, -1, 0);    // zero length
        run_cmd(4'h3, 32'h0000_0000, 23'h1004, 0, -1, 0);    // unaligned length
        run_cmd(4'h7, 32'h0000_0104, 23'h0040, 0, -1, 0);    // unaligned address
        run_cmd(4'hA, 32'h0FFF_F000, 23'h2000, 0, -1, 0);    // out of window, drained
        run_cmd(4'h5, 32'h0000_0100, 23'h1000, 0, -1, 100);  // reset mid-transfer
        run_cmd(4'h6, 32'h0000_0100, 23'h0040, 0, -1, 0);
        run_cmd(4'hA, 32'h0000_0040, 23'h0040, 0, 4, 0);     // early tlast
        run_cmd(4'h1, 32'h0FFF_FF80, 23'h0080, 1, -1, 0);    // exactly fills window
        run_cmd(4'h2, 32'h0FFF_FF88, 23'h0080, 0, -1, 0);    // one beat past window
        run_cmd(4'h4, 32'hFFFF_FFC0, 23'h0080, 0, -1, 0);    // 32-bit wrap

        for (int i = 0; i < 12; i++) begin
            r_bt = 23'($urandom_range(0, 32) * 8);
            if ($urandom_range(0, 5) == 0) r_bt = r_bt | 23'($urandom_range(1, 7));
            if ($urandom_range(0, 2) == 0)
                r_sa = 32'h1000_0000 - 32'($urandom_range(0, 48) * 8);
            else
                r_sa = 32'($urandom_range(0, 4096) * 8);
            if ($urandom_range(0, 5) == 0) r_sa = r_sa | 32'($urandom_range(1, 7));
            run_cmd(4'($urandom), r_sa, r_bt, int'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
